// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op encoding, FSM states and flag bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'b000,
    ALU_MUL      = 3'b001,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110,
    ALU_LSL      = 3'b111
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

  typedef struct packed {
    logic negative;
    logic zero;
    logic overflow;
    logic carry_out;
  } alu_flags_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU ops and flag generation.
// For ALU_MUL the finished product arrives on i_a and only gets its flags computed.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  alu_op_t          i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result_c,
  output alu_flags_t       o_flags_c
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned WP1 = WIDTH + 1;

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_cout;

  always_comb begin
    w_b_eff = '0;
    w_sum   = '0;
    w_res   = '0;
    w_ovf   = 1'b0;
    w_cout  = 1'b0;
    case (i_op)
      ALU_PASS_B: w_res = i_b;
      ALU_MUL:    w_res = i_a;
      ALU_ADD, ALU_SUBTRACT: begin
        // subtraction is A + ~B + 1, so carry_out means "no borrow"
        w_b_eff = (i_op == ALU_SUBTRACT) ? ~i_b : i_b;
        w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + WP1'(i_op == ALU_SUBTRACT);
        w_res   = w_sum[WIDTH-1:0];
        w_cout  = w_sum[WIDTH];
        w_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_AND:    w_res = i_a & i_b;
      ALU_OR:     w_res = i_a | i_b;
      ALU_XOR:    w_res = i_a ^ i_b;
      ALU_LSL:    w_res = i_a << i_b[SHW-1:0];
      default:    w_res = '0;
    endcase
  end

  always_comb begin
    o_result_c          = w_res;
    o_flags_c.negative  = w_res[WIDTH-1];
    o_flags_c.zero      = (w_res == '0);
    o_flags_c.overflow  = w_ovf;
    o_flags_c.carry_out = w_cout;
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops with latency 1, shift-add multiply over WIDTH cycles,
// registered result/flags held under downstream backpressure.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_t       r_state,     w_state_nx;
  logic             r_out_valid, w_out_valid_nx;
  logic [WIDTH-1:0] r_result,    w_result_nx;
  alu_flags_t       r_flags,     w_flags_nx;
  logic [WIDTH-1:0] r_mcand,     w_mcand_nx;
  logic [WIDTH-1:0] r_mplier,    w_mplier_nx;
  logic [WIDTH-1:0] r_acc,       w_acc_nx;
  logic [SHW-1:0]   r_count,     w_count_nx;

  alu_op_t          w_op;
  alu_op_t          w_comb_op;
  logic [WIDTH-1:0] w_comb_a;
  logic [WIDTH-1:0] w_comb_res;
  alu_flags_t       w_comb_flags;
  logic [WIDTH-1:0] w_acc_step;
  logic             w_accept;

  assign w_op       = alu_op_t'(cntrl);
  assign in_ready   = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});

  // The flag unit is shared: during MUL it sees the final accumulator value.
  assign w_comb_op = (r_state == MUL) ? ALU_MUL : w_op;
  assign w_comb_a  = (r_state == MUL) ? w_acc_step : A;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .i_op       (w_comb_op),
    .i_a        (w_comb_a),
    .i_b        (B),
    .o_result_c (w_comb_res),
    .o_flags_c  (w_comb_flags)
  );

  always_comb begin
    w_state_nx     = r_state;
    w_out_valid_nx = r_out_valid;
    w_result_nx    = r_result;
    w_flags_nx     = r_flags;
    w_mcand_nx     = r_mcand;
    w_mplier_nx    = r_mplier;
    w_acc_nx       = r_acc;
    w_count_nx     = r_count;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_op == ALU_MUL) begin
            w_mcand_nx     = A;
            w_mplier_nx    = B;
            w_acc_nx       = '0;
            w_count_nx     = '0;
            w_out_valid_nx = 1'b0;
            w_state_nx     = MUL;
          end else begin
            w_result_nx    = w_comb_res;
            w_flags_nx     = w_comb_flags;
            w_out_valid_nx = 1'b1;
          end
        end else if (r_out_valid && out_ready) begin
          w_out_valid_nx = 1'b0;
        end
      end
      MUL: begin
        w_acc_nx    = w_acc_step;
        w_mcand_nx  = r_mcand << 1;
        w_mplier_nx = r_mplier >> 1;
        w_count_nx  = r_count + SHW'(1);
        if (r_count == SHW'(WIDTH - 1)) begin
          w_result_nx    = w_comb_res;
          w_flags_nx     = w_comb_flags;
          w_out_valid_nx = 1'b1;
          w_state_nx     = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_out_valid <= w_out_valid_nx;
      r_result    <= w_result_nx;
      r_flags     <= w_flags_nx;
      r_mcand     <= w_mcand_nx;
      r_mplier    <= w_mplier_nx;
      r_acc       <= w_acc_nx;
      r_count     <= w_count_nx;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign negative  = r_flags.negative;
  assign zero      = r_flags.zero;
  assign overflow  = r_flags.overflow;
  assign carry_out = r_flags.carry_out;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=64): directed plan cases plus a randomized
// scoreboard run against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [2:0]    cntrl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          negative;
  logic          zero;
  logic          overflow;
  logic          carry_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] cur_flags();
    return {negative, zero, overflow, carry_out};
  endfunction

  // Reference: {negative, zero, overflow, carry_out, result} from plain arithmetic.
  function automatic logic [67:0] ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic [64:0] u;
    logic [64:0] s;
    logic        v;
    logic        c;
    logic [5:0]  sh;
    v  = 1'b0;
    c  = 1'b0;
    sh = b[5:0];
    case (op)
      3'd0: r = b;
      3'd1: r = a * b;
      3'd2: begin
        u = {1'b0, a} + {1'b0, b};
        r = u[63:0];
        c = u[64];
        s = {a[63], a} + {b[63], b};
        v = s[64] ^ s[63];
      end
      3'd3: begin
        r = a - b;
        c = (a >= b);
        s = {a[63], a} - {b[63], b};
        v = s[64] ^ s[63];
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = a << sh;
    endcase
    return {r[63], (r == 64'd0), v, c, r};
  endfunction

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return {64{1'b1}};
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic send_single(input string tag, input logic [2:0] op, input logic [63:0] a,
                             input logic [63:0] b, input logic [63:0] exp_r, input logic [3:0] exp_f);
    @(negedge clk);
    in_valid = 1'b1; cntrl = op; A = a; B = b; out_ready = 1'b1;
    #1 check_eq({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_eq({tag, "_vld"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_res"}, result, exp_r);
    check_eq({tag, "_flg"}, 64'(cur_flags()), 64'(exp_f));
  endtask

  logic [67:0] q[$];
  logic [67:0] e;
  logic        last_fire;
  int          lat;
  int          busy;
  int          stale;
  logic [2:0]  rop;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; cntrl = 3'd0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_vld", 64'(out_valid), 64'd0);
    check_eq("rst_res", result, 64'd0);
    check_eq("rst_flg", 64'(cur_flags()), 64'd0);
    check_eq("rst_rdy", 64'(in_ready), 64'd1);
    reset_n = 1'b1;

    send_single("add_1_1", 3'd2, 64'd1, 64'd1, 64'd2, 4'b0000);
    send_single("sub_5_5", 3'd3, 64'd5, 64'd5, 64'd0, 4'b0101);
    send_single("add_ovf", 3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1010);
    send_single("sub_3_5", 3'd3, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    send_single("lsl_wrap", 3'd7, 64'd1, 64'h41, 64'd2, 4'b0000);
    send_single("lsl_63", 3'd7, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 4'b1000);
    send_single("pass_b", 3'd0, 64'd7, 64'd0, 64'd0, 4'b0100);

    // Multiply latency and busy window
    @(negedge clk);
    in_valid = 1'b1; cntrl = 3'd1; A = 64'd3; B = 64'hFFFF_FFFF_FFFF_FFFE; out_ready = 1'b1;
    #1 check_eq("mul_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; A = '0; B = '0;
    lat = 1; busy = 0;
    while (lat <= 200) begin
      #1;
      if (out_valid) break;
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    check_eq("mul_lat", 64'(lat), 64'd65);
    check_eq("mul_busy", 64'(busy), 64'd64);
    check_eq("mul_res", result, 64'hFFFF_FFFF_FFFF_FFFA);
    check_eq("mul_flg", 64'(cur_flags()), 64'b1000);

    // Backpressure: XOR result held while an ADD waits
    send_single("xor", 3'd6, 64'hF0, 64'hFF, 64'h0F, 4'b0000);
    out_ready = 1'b0; in_valid = 1'b1; cntrl = 3'd2; A = 64'h10; B = 64'h20;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_hold_res", result, 64'h0F);
      check_eq("bp_hold_vld", 64'(out_valid), 64'd1);
      check_eq("bp_hold_rdy", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check_eq("bp_rel_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_eq("bp_new_vld", 64'(out_valid), 64'd1);
    check_eq("bp_new_res", result, 64'h30);
    @(negedge clk);
    #1 check_eq("bp_drained", 64'(out_valid), 64'd0);

    // Reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; cntrl = 3'd1; A = 64'd12345; B = 64'd678; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    check_eq("mrst_vld", 64'(out_valid), 64'd0);
    check_eq("mrst_res", result, 64'd0);
    check_eq("mrst_rdy", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    stale = 0;
    repeat (80) begin
      @(negedge clk);
      #1 if (out_valid) stale++;
    end
    check_eq("mrst_stale", 64'(stale), 64'd0);

    // Randomized traffic against the scoreboard
    last_fire = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!(in_valid && !last_fire)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rop = 3'($urandom_range(0, 7));
        if (rop == 3'd1 && $urandom_range(0, 2) != 0) rop = 3'd2;
        cntrl = rop; A = pick_val(); B = pick_val();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check_eq("rnd_spurious", 64'(out_valid), 64'd0);
        else begin
          e = q.pop_front();
          check_eq("rnd_res", result, e[63:0]);
          check_eq("rnd_flg", 64'(cur_flags()), 64'(e[67:64]));
        end
      end
      last_fire = in_valid && in_ready;
      if (last_fire) q.push_back(ref_alu(cntrl, A, B));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 150; c++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) check_eq("drain_spurious", 64'(out_valid), 64'd0);
        else begin
          e = q.pop_front();
          check_eq("drain_res", result, e[63:0]);
          check_eq("drain_flg", 64'(cur_flags()), 64'(e[67:64]));
        end
      end
      @(negedge clk);
    end
    check_eq("rnd_left", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 64-bit combinational ALU used in the datapath.
- Generalises operand width via WIDTH and registers result and flags.
- Adds two ops: multi-cycle iterative multiply and single-cycle logical shift left.
- Sits between register-file read and writeback; valid/ready on both sides lets the pipeline stall on multiply or downstream backpressure.

Parameters:
- WIDTH, 64, operand/result width in bits; legal values are powers of two, 8 to 64.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operands and op are presented.
- in_ready, output, 1, block accepts when in_valid && in_ready.
- A, input, WIDTH, operand A.
- B, input, WIDTH, operand B.
- cntrl, input, 3, operation select.
- out_valid, output, 1, result/flags valid.
- out_ready, input, 1, consumer takes result when out_valid && out_ready.
- result, output, WIDTH, registered result.
- negative, output, 1, result[WIDTH-1].
- zero, output, 1, result == 0.
- overflow, output, 1, signed overflow (ADD/SUB only, else 0).
- carry_out, output, 1, carry out of the MSB (ADD/SUB only, else 0).

Behaviour:
- Op encoding (cntrl):
  - 000 PASS_B: result = B.
  - 001 MUL: result = low WIDTH bits of A*B.
  - 010 ADD: result = A+B.
  - 011 SUB: result = A+~B+1.
  - 100 AND, 101 OR, 110 XOR: bitwise.
  - 111 LSL: result = A << B[SHW-1:0].
- Reset (reset_n=0 at posedge): state=IDLE; out_valid=0; result=0; all flags=0; multiply accumulators cleared. Reset overrides everything, including mid-MUL and a held output; the in-flight op is discarded with no output.
- States:
  - IDLE: in_ready = !out_valid || out_ready.
  - MUL: in_ready=0.
- Single-cycle op accepted in IDLE: result and flags are loaded at the accepting edge; out_valid=1 the next cycle (latency 1). Back-to-back accepts are allowed when out_ready=1 (throughput 1/cycle).
- MUL accepted: latch A into a multiplicand register and B into a multiplier register; acc=0; count=0; go to MUL.
  - Each MUL cycle: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count++.
  - After WIDTH iterations: load result=acc and flags; go to IDLE; out_valid=1.
  - Accept-to-out_valid latency is exactly WIDTH+1 cycles. There is no early termination.
- Output hold: while out_valid && !out_ready, result and flags are frozen and in_ready=0.
  - out_valid clears on the handshake edge unless a new op is accepted on the same edge. In that case the new single-cycle result replaces it and out_valid stays 1.
- Flags:
  - Flags are computed from the new result at load time.
  - overflow = carry into MSB XOR carry out of MSB, for ADD/SUB only.
  - carry_out for SUB = 1 when A >= B unsigned (no borrow).
  - MUL, LSL and the logical ops force overflow=0 and carry_out=0.
- in_valid with in_ready=0: no effect. The source holds its inputs.
- Inputs are sampled only at the accepting edge; later changes do not affect an in-flight op.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_t, with ALU_PASS_B, ALU_MUL, ALU_ADD, ALU_SUBTRACT, ALU_AND, ALU_OR, ALU_XOR, ALU_LSL.
  - typedef enum logic alu_state_t {IDLE, MUL}.
- One sub-module, alu_comb #(WIDTH): combinational single-cycle ops plus flag generation, shared by the single-cycle path and the final MUL flag computation.
- The FSM, multiply datapath and output register live in alu_seq.

Test Plan (WIDTH=64):
- ADD, A=1, B=1, out_ready=1: result=2 one cycle after accept; negative=0, zero=0, overflow=0, carry_out=0.
- SUB, A=5, B=5: result=0; zero=1, carry_out=1, overflow=0, negative=0.
- ADD, A=0x7FFF_FFFF_FFFF_FFFF, B=1: result=0x8000_0000_0000_0000; overflow=1, negative=1, carry_out=0.
- MUL, A=3, B=0xFFFF_FFFF_FFFF_FFFE:
  - in_ready=0 for 64 cycles; out_valid exactly 65 cycles after accept.
  - result=0xFFFF_FFFF_FFFF_FFFA; negative=1, overflow=0, carry_out=0.
- Backpressure: XOR, A=0xF0, B=0xFF, then out_ready=0 for 5 cycles while in_valid=1 with ADD.
  - result holds 0x0F; in_ready=0; ADD is not accepted.
  - On out_ready=1, the ADD is accepted on the same edge and out_valid stays 1.
- Reset mid-MUL: drop reset_n at cycle 10 of a MUL → next cycle out_valid=0, result=0, in_ready=1; no stale result ever appears.
